// File: rtl/aes_key_expand_pkg.sv
// Shared AES-256 constants: widths, round count and the key-schedule Rcon table.
// The encrypt datapath imports the same package so both sides agree on them.
package aes_key_expand_pkg;

  localparam int KEY_W   = 256;
  localparam int BLK_W   = 128;
  localparam int WORD_W  = 32;
  localparam int ROUND_W = 4;

  localparam logic [ROUND_W-1:0] AES_ROUNDS = 4'd14;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BLK_W-1:0]  block_t;

  // Index 0 and anything past 7 never reach an even-step g, so they return 0.
  function automatic logic [7:0] rcon(input logic [ROUND_W-1:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Control and key/round-key bus between a round controller and the key expander.
interface aes_key_expand_if;
  import aes_key_expand_pkg::*;

  logic                 Start;
  logic [KEY_W-1:0]     Key;
  logic                 Next;
  block_t               RoundKey;
  logic [ROUND_W-1:0]   Round;
  logic                 Valid;
  logic                 Done;

  modport master (
    output Start, Key, Next,
    input  RoundKey, Round, Valid, Done
  );

  modport slave (
    input  Start, Key, Next,
    output RoundKey, Round, Valid, Done
  );
endinterface

// File: rtl/aes_key_expand_sbox.sv
// AES S-box as pure logic: GF(2^8) inverse (x^254, so 0 maps to 0) then the affine map.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] w_inv;

  // Accumulates x^2 * x^4 * ... * x^128 = x^254, the multiplicative inverse.
  always_comb begin
    logic [7:0] sq;
    sq    = i_byte;
    w_inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq    = gf_mul(sq, sq);
      w_inv = gf_mul(w_inv, sq);
    end
  end

  assign o_byte = w_inv
                ^ {w_inv[6:0], w_inv[7]}
                ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]}
                ^ {w_inv[3:0], w_inv[7:4]}
                ^ 8'h63;

endmodule

// File: rtl/aes_key_expand.sv
// AES-256 round-key generator: a {KA, KB} window that slides one round key per Next.
// KA is the current round key; KB is precomputed one round ahead.
module aes_key_expand
  import aes_key_expand_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  aes_key_expand_if.slave  bus
);

  block_t              r_ka;
  block_t              r_kb;
  logic [ROUND_W-1:0]  r_round;
  logic                r_valid;

  word_t               w_kb3;
  word_t               w_sub_in;
  word_t               w_sub_out;
  word_t               w_g;
  logic                w_even;
  logic [ROUND_W-1:0]  w_round_p2;
  logic [ROUND_W-1:0]  w_rcon_idx;
  block_t              w_new_kb;
  logic                w_step;

  // Round+2 shares parity with Round, so the LSB selects the g variant.
  assign w_kb3      = r_kb[WORD_W-1:0];
  assign w_even     = ~r_round[0];
  assign w_sub_in   = w_even ? {w_kb3[23:0], w_kb3[31:24]} : w_kb3;
  assign w_round_p2 = r_round + 4'd2;
  assign w_rcon_idx = w_round_p2 >> 1;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
      aes_sbox u_sbox (
        .i_byte (w_sub_in[8*gi +: 8]),
        .o_byte (w_sub_out[8*gi +: 8])
      );
    end
  endgenerate

  assign w_g = w_sub_out ^ (w_even ? {rcon(w_rcon_idx), 24'h000000} : 32'h00000000);

  // Word 0 sits in the top bits; each later word chains on the one before it.
  always_comb begin
    word_t prev;
    w_new_kb = '0;
    prev     = r_ka[BLK_W-1 -: WORD_W] ^ w_g;
    w_new_kb[BLK_W-1 -: WORD_W] = prev;
    for (int k = 1; k < 4; k++) begin
      prev = r_ka[BLK_W-1-WORD_W*k -: WORD_W] ^ prev;
      w_new_kb[BLK_W-1-WORD_W*k -: WORD_W] = prev;
    end
  end

  assign w_step = bus.Next && r_valid && (r_round < AES_ROUNDS);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_ka    <= '0;
      r_kb    <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
    end else if (bus.Start) begin
      r_ka    <= bus.Key[KEY_W-1 -: BLK_W];
      r_kb    <= bus.Key[BLK_W-1:0];
      r_round <= '0;
      r_valid <= 1'b1;
    end else if (w_step) begin
      r_ka    <= r_kb;
      r_round <= r_round + 4'd1;
      // Stepping 13 -> 14 has no round key 15 to prepare.
      if (r_round != AES_ROUNDS - 4'd1) begin
        r_kb <= w_new_kb;
      end
    end
  end

  assign bus.RoundKey = r_ka;
  assign bus.Round    = r_round;
  assign bus.Valid    = r_valid;
  assign bus.Done     = r_valid && (r_round == AES_ROUNDS);

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboarded bench: a FIPS-197 style word-by-word key schedule predicts every cycle.
module tb_aes_key_expand;

  logic Clk;
  logic Rst;

  aes_key_expand_if bus_if ();

  aes_key_expand dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus_if)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    bit           valid;
    int           round;
    logic [127:0] key;
    bit           done;
  } exp_t;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  int           txn    = 0;

  logic [7:0]   sbox_tab [256];
  logic [31:0]  w_ref    [60];
  int           m_round;
  bit           m_valid;

  localparam logic [255:0] FIPS_KEY =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] bmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && bmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] k);
    for (int i = 0; i < 8; i++) w_ref[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      logic [31:0] t;
      t = w_ref[i-1];
      if (i % 8 == 0)
        t = sub_word({t[23:0], t[31:24]}) ^ {8'(1 << (i/8 - 1)), 24'h0};
      else if (i % 8 == 4)
        t = sub_word(t);
      w_ref[i] = w_ref[i-8] ^ t;
    end
  endtask

  function automatic logic [127:0] ref_key(input int r);
    return {w_ref[4*r], w_ref[4*r+1], w_ref[4*r+2], w_ref[4*r+3]};
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.valid = m_valid;
    e.round = m_round;
    e.key   = m_valid ? ref_key(m_round) : 128'h0;
    e.done  = m_valid && (m_round == 14);
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // One clock: drive inputs, advance the reference, queue its post-edge prediction.
  task automatic cyc(input bit s, input bit n, input logic [255:0] k);
    exp_t e;
    bus_if.Start = s;
    bus_if.Next  = n;
    bus_if.Key   = k;
    if (!Rst) begin
      m_valid = 0;
      m_round = 0;
    end else if (s) begin
      expand(k);
      m_round = 0;
      m_valid = 1;
    end else if (n && m_valid && m_round < 14) begin
      m_round++;
    end
    e = model_out();
    @(posedge Clk);
    sb.push_back(e);
    #1;
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      txn++;
      $display("txn %0d start=%0b next=%0b round=%0d valid=%0b done=%0b key=%h",
               txn, bus_if.Start, bus_if.Next, bus_if.Round, bus_if.Valid, bus_if.Done,
               bus_if.RoundKey);
      chk("sb_valid", 128'(bus_if.Valid), 128'(e.valid));
      chk("sb_round", 128'(bus_if.Round), 128'(e.round));
      chk("sb_key",   bus_if.RoundKey,    e.key);
      chk("sb_done",  128'(bus_if.Done),  128'(e.done));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [255:0] k2;
    Rst          = 1'b0;
    bus_if.Start = 1'b0;
    bus_if.Next  = 1'b0;
    bus_if.Key   = '0;
    m_round      = 0;
    m_valid      = 0;
    build_sbox();
    #1;
    chk("reset_key",   bus_if.RoundKey,     128'h0);
    chk("reset_valid", 128'(bus_if.Valid),  128'h0);
    chk("reset_done",  128'(bus_if.Done),   128'h0);

    cyc(0, 0, '0);
    cyc(0, 1, '0);
    Rst = 1'b1;

    // Next before any Start must not move anything.
    repeat (3) cyc(0, 1, rand_key());

    cyc(1, 0, FIPS_KEY);
    chk("fips_r0_key",   bus_if.RoundKey,    128'h603deb1015ca71be2b73aef0857d7781);
    chk("fips_r0_round", 128'(bus_if.Round), 128'd0);
    cyc(0, 1, '0);
    cyc(0, 1, '0);
    chk("fips_r2_key",   bus_if.RoundKey,    128'h9ba354118e6925afa51a8b5f2067fcde);
    chk("fips_r2_round", 128'(bus_if.Round), 128'd2);

    cyc(1, 0, FIPS_KEY);
    repeat (20) cyc(0, 1, '0);
    chk("fips_r14_key",  bus_if.RoundKey,    128'hfe4890d1e6188d0b046df344706c631e);
    chk("fips_r14_round",128'(bus_if.Round), 128'd14);
    chk("fips_r14_done", 128'(bus_if.Done),  128'd1);
    repeat (3) cyc(0, 1, '0);
    chk("sat_key",       bus_if.RoundKey,    128'hfe4890d1e6188d0b046df344706c631e);

    // Start beats Next at round 5.
    cyc(1, 0, rand_key());
    repeat (5) cyc(0, 1, '0);
    k2 = rand_key();
    cyc(1, 1, k2);
    chk("restart_round", 128'(bus_if.Round), 128'd0);
    chk("restart_key",   bus_if.RoundKey,    k2[255:128]);

    // Asynchronous reset at round 7, checked between clock edges.
    cyc(1, 0, rand_key());
    repeat (7) cyc(0, 1, '0);
    @(negedge Clk);
    #1;
    Rst = 1'b0;
    m_valid = 0;
    m_round = 0;
    #1;
    chk("async_key",   bus_if.RoundKey,    128'h0);
    chk("async_round", 128'(bus_if.Round), 128'd0);
    chk("async_valid", 128'(bus_if.Valid), 128'd0);
    cyc(0, 1, '0);
    Rst = 1'b1;
    repeat (2) cyc(0, 1, '0);

    for (int it = 0; it < 6; it++) begin
      cyc(1, 0, rand_key());
      for (int c = 0; c < 30; c++)
        cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), rand_key());
    end

    bus_if.Start = 1'b0;
    bus_if.Next  = 1'b0;
    repeat (3) @(negedge Clk);
    chk("sb_drained", 128'(sb.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 Clk  input  1  rising-edge clock.
REQ-002 Rst  input  1  asynchronous, active-low reset.
REQ-003 Start  input  1  load Key and restart the schedule at round 0.
REQ-004 Key  input  256  AES-256 cipher key, MSB = first key byte; sampled only when Start=1.
REQ-005 Next  input  1  advance to the next round key; driven by the same enable as the round counter.
REQ-006 RoundKey  output  128  current round key, MSB = first byte.
REQ-007 Round  output  4  index of the current RoundKey, 0..14.
REQ-008 Valid  output  1  RoundKey/Round hold a key derived from a loaded Key.
REQ-009 Done  output  1  Valid=1 and Round=14.

Function
REQ-010 State SHALL be a 256-bit window {KA, KB}: KA = round key r (drives RoundKey), KB = round key r+1.
REQ-011 Start=1 SHALL, after 1 clock, give KA=Key[255:128], KB=Key[127:0], Round=0, Valid=1.
REQ-012 Start SHALL take priority over Next in the same cycle.
REQ-013 Next=1 with Valid=1 and Round<14 SHALL, after 1 clock, give Round=Round+1, KA=old KB, KB=round key Round+2.
REQ-014 Next with Round=14 SHALL hold all state (saturate), matching the round counter's saturation at 14.
REQ-015 Next with Valid=0 SHALL be ignored.
REQ-016 New KB words w0..w3 SHALL be: w0 = KA.word0 XOR g(KB.word3); wk = KA.wordk XOR w(k-1) for k=1..3 (word0 = bits 127:96).
REQ-017 If (Round+2) is even, g(x) SHALL be SubWord(RotWord(x)) XOR {Rcon[(Round+2)/2], 24'h0}.
REQ-018 If (Round+2) is odd, g(x) SHALL be SubWord(x) only.
REQ-019 Rcon[1..7] SHALL be 01,02,04,08,10,20,40 (hex).
REQ-020 RotWord SHALL be a cyclic left rotation by one byte; SubWord SHALL apply the AES S-box to each byte.
REQ-021 At Round=13 a Next SHALL update KA and Round only; KB content is unspecified thereafter.
REQ-022 Next while Round is advancing SHALL produce exactly one step per asserted cycle, with no stall.
REQ-023 Start while Next is active mid-schedule SHALL discard the old schedule immediately.
REQ-024 Done SHALL be combinational from Valid and Round.

Reset
REQ-025 Rst=0 SHALL asynchronously clear KA, KB, Round and Valid to 0; RoundKey=0 and Done=0.
REQ-026 After reset is released, the block SHALL ignore Next until a Start is received.

Structure
REQ-027 The Rcon table, the AES-256 round count (14) and the key/word widths SHALL live in a shared AES package that the encrypt datapath also uses.
REQ-028 The S-box SHALL be one combinational sub-module, aes_sbox (8-bit in, 8-bit out), instantiated 4 times for SubWord.
REQ-029 The key expansion SHALL compute one word of g per cycle, so only 4 S-box instances are required.

Verification
REQ-030 Reset mid-run (Round=7) -> RoundKey=0, Round=0, Valid=0 immediately, without waiting for a clock.
REQ-031 Start with Key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> Round=0, RoundKey=603deb1015ca71be2b73aef0857d7781.
REQ-032 Two Next pulses after the REQ-031 load -> Round=2, RoundKey=9ba354118e6925afa51a8b5f2067fcde.
REQ-033 Next held for 20 cycles after the REQ-031 load -> Round=14, RoundKey=fe4890d1e6188d0b046df344706c631e, Done=1, held stable.
REQ-034 Start and Next asserted together at Round=5 -> Round=0, RoundKey=Key[255:128] on the next cycle.
REQ-035 Next with Valid=0 after reset -> Round=0, Valid=0 unchanged; Round tracks a reference counter fed the same Next/Start stream in every test.
